multicycle_control_unit: RTL and testbench

Multi-cycle RV32I control unit: a registered FSM that sequences one instruction over 3–5 cycles through a shared datapath (single memory port, one ALU, IR/OldPC/ALUOut/Data registers). It supersedes the single-cycle decoder by adding:
- JAL, LUI, the full branch set and SRA/SLT/SLTU;
- a memory-ready handshake;
- a configurable illegal-opcode policy.

It drives every datapath mux/enable from the current state plus the IR fields.

---
 rtl/mcu_pkg.sv | 73 +++++++
 rtl/multicycle_control_unit_if.sv | 29 ++
 rtl/multicycle_control_unit_alu_decoder.sv | 34 +++
 rtl/multicycle_control_unit.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mcu_pkg;

    // Controller states; FETCH is the reset state and must encode as zero.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_LUI      = 4'd10,
        S_BRANCH   = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    // ALU operation class handed from the FSM to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // True for every opcode this controller knows how to sequence.
    function automatic logic is_known_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) ||
               (op == OP_IMM) || (op == OP_JAL) || (op == OP_BRANCH) ||
               (op == OP_LUI);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multi-cycle controller (master) and its datapath (slave).
interface multicycle_control_unit_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       ZF, SF, CF, VF;
    logic       mem_ready;
    logic       mem_req;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       illegal;
    logic       retire;

    modport master (
        input  op, funct3, funct7_5, ZF, SF, CF, VF, mem_ready,
        output mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, retire
    );

    modport slave (
        output op, funct3, funct7_5, ZF, SF, CF, VF, mem_ready,
        input  mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, retire
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: ALUOp class plus instruction fields to ALUControl.
module alu_decoder
    import mcu_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op5,
    output logic [3:0] alu_control
);

    // Select the ALU function; only R-type (op5=1) may turn funct3=000 into sub.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: sequences one instruction over 3-5 cycles
// through a shared datapath and drives its muxes and enables.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ILLEGAL_HALT  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_unit_if.master  bus
);

    state_t  state, state_next;
    alu_op_t alu_op;
    logic    ready;
    logic    taken;

    // Without the handshake every access completes in a single cycle.
    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    // State register; asynchronous reset lands in FETCH immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking for registered state so all flops update together.
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Next-state selection from the current state, opcode and memory ready.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECUTER;
                    OP_IMM:            state_next = S_EXECUTEI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (ready) state_next = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    // Branch condition from the flags of the rs1-rs2 subtraction.
    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.ZF;
            3'b001:  taken = ~bus.ZF;
            3'b100:  taken = bus.SF ^ bus.VF;
            3'b101:  taken = ~(bus.SF ^ bus.VF);
            3'b110:  taken = ~bus.CF;
            3'b111:  taken = bus.CF;
            default: taken = 1'b0;
        endcase
    end

    // Datapath controls per state; unlisted signals stay at their idle defaults.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RS2;
        bus.illegal   = 1'b0;
        bus.retire    = 1'b0;
        alu_op        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                bus.IRWrite   = ready;
                bus.PCWrite   = ready;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                bus.retire  = !ILLEGAL_HALT && !is_known_op(bus.op);
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
                bus.retire    = 1'b1;
            end
            S_MEMWRITE: begin
                bus.mem_req  = 1'b1;
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                bus.retire   = ready;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = SRCA_RS1;
                alu_op      = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
            end
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCWrite = 1'b1;
            end
            S_LUI: begin
                bus.ALUSrcA = SRCA_ZERO;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_BRANCH: begin
                bus.ALUSrcA = SRCA_RS1;
                alu_op      = ALUOP_SUB;
                bus.PCWrite = taken;
                bus.retire  = 1'b1;
            end
            S_HALT:  bus.illegal = 1'b1;
            default: ;
        endcase
    end

    // Immediate format depends on the opcode alone.
    always_comb begin
        case (bus.op)
            OP_LOAD, OP_IMM: bus.ImmSrc = IMM_I;
            OP_STORE:        bus.ImmSrc = IMM_S;
            OP_BRANCH:       bus.ImmSrc = IMM_B;
            OP_JAL:          bus.ImmSrc = IMM_J;
            OP_LUI:          bus.ImmSrc = IMM_U;
            default:         bus.ImmSrc = 3'b000;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7_5    (bus.funct7_5),
        .op5         (bus.op[5]),
        .alu_control (bus.ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction behaviour (latency, enable pulses, ALU
// function, branch decision) predicted from the ISA-level rules and compared
// against two controller builds sharing one stimulus.
module tb_multicycle_control_unit;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LU  = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       zf = 1'b0, sf = 1'b0, cf = 1'b0, vf = 1'b0;
    logic       mem_ready = 1'b0;
    logic       sel = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if bus_a ();
    multicycle_control_unit_if bus_b ();

    assign bus_a.op = op;          assign bus_b.op = op;
    assign bus_a.funct3 = funct3;  assign bus_b.funct3 = funct3;
    assign bus_a.funct7_5 = funct7_5; assign bus_b.funct7_5 = funct7_5;
    assign bus_a.ZF = zf;          assign bus_b.ZF = zf;
    assign bus_a.SF = sf;          assign bus_b.SF = sf;
    assign bus_a.CF = cf;          assign bus_b.CF = cf;
    assign bus_a.VF = vf;          assign bus_b.VF = vf;
    assign bus_a.mem_ready = mem_ready; assign bus_b.mem_ready = mem_ready;

    multicycle_control_unit #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_HALT(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.master)
    );

    multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .ILLEGAL_HALT(1'b0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.master)
    );

    typedef struct packed {
        logic       mem_req;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       illegal;
        logic       retire;
        logic [3:0] alu;
    } obs_t;

    obs_t obs;

    always_comb begin
        obs = sel ? {bus_b.mem_req, bus_b.PCWrite, bus_b.IRWrite, bus_b.RegWrite,
                     bus_b.MemWrite, bus_b.illegal, bus_b.retire, bus_b.ALUControl}
                  : {bus_a.mem_req, bus_a.PCWrite, bus_a.IRWrite, bus_a.RegWrite,
                     bus_a.MemWrite, bus_a.illegal, bus_a.retire, bus_a.ALUControl};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // RV32I ALU operation for an R-type or OP-IMM instruction.
    function automatic logic [3:0] exp_alu(input bit r_type, input logic [2:0] f3, input logic f75);
        case (f3)
            3'd0: return (r_type && f75) ? 4'd2 : 4'd0;   // sub / add(i)
            3'd1: return 4'd1;                            // sll
            3'd2: return 4'd3;                            // slt
            3'd3: return 4'd9;                            // sltu
            3'd4: return 4'd4;                            // xor
            3'd5: return f75 ? 4'd8 : 4'd5;               // sra / srl
            3'd6: return 4'd6;                            // or
            default: return 4'd7;                         // and
        endcase
    endfunction

    // Branch decision from subtraction flags: signed less-than is SF!=VF,
    // unsigned less-than is a borrow (CF=0).
    function automatic bit exp_taken(input logic [2:0] f3, input logic [3:0] fl);
        bit z, s, c, v;
        {z, s, c, v} = fl;
        case (f3)
            3'd0: return z;           // beq
            3'd1: return !z;          // bne
            3'd4: return s != v;      // blt
            3'd5: return s == v;      // bge
            3'd6: return !c;          // bltu
            3'd7: return c;           // bgeu
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Run one instruction starting in FETCH just after a clock edge.
    // fw / mw = cycles mem_ready is held low in FETCH / in the memory state.
    task automatic run_instr(input logic [6:0] op_i, input logic [2:0] f3_i, input logic f75_i,
                             input int fw, input int mw, input logic [3:0] fl);
        bit is_ld, is_st, is_r, is_i, is_j, is_b, is_u, known, hs, is_mem, done;
        int base, efw, emw, exp_cycles, exp_reg, exp_mw, exp_req, exp_pc;
        int cycles, c_ir, c_reg, c_mw, c_req, c_pc, c_ill, reg_last;
        logic [3:0] alu_seen;
        is_ld = (op_i == LD); is_st = (op_i == ST); is_r = (op_i == RT);
        is_i  = (op_i == IT); is_j  = (op_i == JL); is_b = (op_i == BR);
        is_u  = (op_i == LU);
        known = is_ld | is_st | is_r | is_i | is_j | is_b | is_u;
        is_mem = is_ld | is_st;
        hs    = (sel == 1'b0);
        base  = is_b ? 3 : is_ld ? 5 : !known ? 2 : 4;
        efw   = hs ? fw : 0;
        emw   = (hs && is_mem) ? mw : 0;
        exp_cycles = base + efw + emw;
        exp_reg = (is_ld | is_r | is_i | is_j | is_u) ? 1 : 0;
        exp_mw  = is_st ? emw + 1 : 0;
        exp_req = efw + 1 + (is_mem ? emw + 1 : 0);
        exp_pc  = 1 + (is_j ? 1 : 0) + ((is_b && exp_taken(f3_i, fl)) ? 1 : 0);

        op = op_i; funct3 = f3_i; funct7_5 = f75_i;
        {zf, sf, cf, vf} = fl;
        done = 1'b0; cycles = 0; c_ir = 0; c_reg = 0; c_mw = 0; c_req = 0;
        c_pc = 0; c_ill = 0; reg_last = 0; alu_seen = 4'hF;
        for (int k = 0; k < 64 && !done; k++) begin
            mem_ready = !((k < fw) || (is_mem && k >= fw + 3 && k < fw + 3 + mw));
            @(negedge clk);
            c_ir  += int'(obs.ir_write);
            c_reg += int'(obs.reg_write);
            c_mw  += int'(obs.mem_write);
            c_req += int'(obs.mem_req);
            c_pc  += int'(obs.pc_write);
            c_ill += int'(obs.illegal);
            if (k == efw + 2) alu_seen = obs.alu;
            if (obs.retire) begin
                done = 1'b1;
                cycles = k + 1;
                reg_last = int'(obs.reg_write);
            end
            @(posedge clk);
            #1;
        end
        check("retire_seen", 32'(done), 32'd1);
        check("cycles", 32'(cycles), 32'(exp_cycles));
        check("irwrite_pulses", 32'(c_ir), 32'd1);
        check("regwrite_cycles", 32'(c_reg), 32'(exp_reg));
        check("regwrite_on_last", 32'(reg_last), 32'(exp_reg));
        check("memwrite_cycles", 32'(c_mw), 32'(exp_mw));
        check("mem_req_cycles", 32'(c_req), 32'(exp_req));
        check("pcwrite_cycles", 32'(c_pc), 32'(exp_pc));
        check("illegal_cycles", 32'(c_ill), 32'd0);
        if (is_r || is_i)
            check("alu_control", 32'(alu_seen), 32'(exp_alu(is_r, f3_i, f75_i)));
    endtask

    logic [6:0] good_ops [7] = '{LD, ST, RT, IT, JL, BR, LU};
    logic [6:0] bad_ops  [4] = '{7'b0000000, 7'b0010111, 7'b1100111, 7'b1110011};

    initial begin
        // Reset holds FETCH: request asserted, fetch enables follow mem_ready.
        sel = 1'b0; mem_ready = 1'b0;
        #1;
        check("rst_mem_req", 32'(obs.mem_req), 32'd1);
        check("rst_irwrite_low", 32'(obs.ir_write), 32'(mem_ready));
        check("rst_misc", 32'({obs.reg_write, obs.mem_write, obs.illegal, obs.retire}), 32'd0);
        mem_ready = 1'b1;
        #1;
        check("rst_irwrite_high", 32'(obs.ir_write), 32'(mem_ready));
        check("rst_pcwrite_high", 32'(obs.pc_write), 32'(mem_ready));
        do_reset();

        // Directed instructions on the handshaking build.
        run_instr(RT, 3'd0, 1'b0, 0, 0, 4'b0000);  // add
        run_instr(IT, 3'd0, 1'b1, 0, 0, 4'b0000);  // addi, IR[30]=1
        run_instr(RT, 3'd0, 1'b1, 0, 0, 4'b0000);  // sub
        run_instr(IT, 3'd5, 1'b1, 0, 0, 4'b0000);  // srai
        run_instr(BR, 3'd0, 1'b0, 0, 0, 4'b1000);  // beq, ZF=1
        run_instr(BR, 3'd4, 1'b0, 0, 0, 4'b0100);  // blt, SF=1 VF=0
        run_instr(BR, 3'd7, 1'b0, 0, 0, 4'b0000);  // bgeu, CF=0
        run_instr(LD, 3'd2, 1'b0, 2, 3, 4'b0000);  // lw with waits
        run_instr(ST, 3'd2, 1'b0, 1, 2, 4'b0000);  // sw with waits
        run_instr(JL, 3'd0, 1'b0, 0, 0, 4'b0000);
        run_instr(LU, 3'd0, 1'b0, 0, 0, 4'b0000);

        // Random instruction stream.
        for (int n = 0; n < 150; n++)
            run_instr(good_ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), 4'($urandom_range(0, 15)));

        // Asynchronous reset in the middle of a waiting store.
        op = ST; funct3 = 3'd2; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        check("store_wait_memwrite", 32'(obs.mem_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_memwrite", 32'(obs.mem_write), 32'd0);
        check("async_rst_mem_req", 32'(obs.mem_req), 32'd1);
        check("async_rst_irwrite", 32'(obs.ir_write), 32'(mem_ready));
        mem_ready = 1'b1;
        #1;
        check("async_rst_fetch_ir", 32'(obs.ir_write), 32'(mem_ready));
        @(posedge clk);
        #1 rst = 1'b0;

        // Unknown opcode with halting enabled: HALT sticks until reset.
        op = 7'b0000000; mem_ready = 1'b1;
        @(negedge clk);
        check("halt_fetch_ir", 32'(obs.ir_write), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("halt_decode_retire", 32'({obs.retire, obs.illegal}), 32'd0);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("halt_outputs",
                  32'({obs.mem_req, obs.pc_write, obs.ir_write, obs.reg_write,
                       obs.mem_write, obs.illegal, obs.retire}), 32'b0000010);
        end
        do_reset();
        @(negedge clk);
        check("halt_cleared", 32'(obs.illegal), 32'd0);
        @(posedge clk); #1;
        do_reset();

        // Non-halting, non-handshaking build.
        sel = 1'b1;
        do_reset();
        run_instr(7'b0000000, 3'd0, 1'b0, 0, 0, 4'b0000);
        run_instr(LD, 3'd2, 1'b0, 2, 3, 4'b0000);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0)
                run_instr(bad_ops[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3),
                          $urandom_range(0, 3), 4'($urandom_range(0, 15)));
            else
                run_instr(good_ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3),
                          $urandom_range(0, 3), 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
